// File: rtl/bcd_fib_seq_pkg.sv
// Shared definitions for the BCD Fibonacci sweep sequencer: digit width,
// FSM state encoding and the limit-digit clamp.
package bcd_fib_seq_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    // Switch digits above 9 are not valid BCD; treat them as 9.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/bcd_inc2.sv
// Combinational two-digit BCD increment of the sweep index plus the
// equality compare against the latched sweep limit.
module bcd_inc2
    import bcd_fib_seq_pkg::*;
(
    input  bcd_digit_t idx1_i,
    input  bcd_digit_t idx0_i,
    input  bcd_digit_t lim1_i,
    input  bcd_digit_t lim0_i,
    output bcd_digit_t inc1_o,
    output bcd_digit_t inc0_o,
    output logic       at_lim_o
);

    // Index 99 is always the limit, so the tens digit never needs to wrap.
    always_comb begin
        if (idx0_i == 4'd9) begin
            inc0_o = '0;
            inc1_o = idx1_i + 4'd1;
        end else begin
            inc0_o = idx0_i + 4'd1;
            inc1_o = idx1_i;
        end
    end

    assign at_lim_o = (idx1_i == lim1_i) && (idx0_i == lim0_i);

endmodule

// File: rtl/bcd_fib_seq.sv
// Sweeps a BCD index 00..limit through an external BCD Fibonacci datapath,
// holding each result on the display for DWELL cycles.
module bcd_fib_seq
    import bcd_fib_seq_pkg::*;
#(
    parameter int unsigned DWELL   = 50_000_000,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [BCD_W-1:0] lim_bcd1,
    input  logic [BCD_W-1:0] lim_bcd0,
    output logic             fib_start,
    output logic [BCD_W-1:0] fib_bcd1,
    output logic [BCD_W-1:0] fib_bcd0,
    input  logic             fib_done,
    input  logic [BCD_W-1:0] fib_d3,
    input  logic [BCD_W-1:0] fib_d2,
    input  logic [BCD_W-1:0] fib_d1,
    input  logic [BCD_W-1:0] fib_d0,
    output logic [BCD_W-1:0] out_d3,
    output logic [BCD_W-1:0] out_d2,
    output logic [BCD_W-1:0] out_d1,
    output logic [BCD_W-1:0] out_d0,
    output logic             busy,
    output logic             err
);

    localparam int unsigned DW_W = (DWELL > 1)   ? $clog2(DWELL)   : 1;
    localparam int unsigned TM_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]         state_q, state_d;
    bcd_digit_t         idx1_q, idx1_d, idx0_q, idx0_d;
    bcd_digit_t         lim1_q, lim1_d, lim0_q, lim0_d;
    logic [4*BCD_W-1:0] out_q, out_d;
    logic               err_q, err_d;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic [TM_W-1:0]    tmo_q, tmo_d;

    bcd_digit_t inc1, inc0;
    logic       at_lim;

    bcd_inc2 u_inc (
        .idx1_i   (idx1_q),
        .idx0_i   (idx0_q),
        .lim1_i   (lim1_q),
        .lim0_i   (lim0_q),
        .inc1_o   (inc1),
        .inc0_o   (inc0),
        .at_lim_o (at_lim)
    );

    always_comb begin
        state_d = state_q;
        idx1_d  = idx1_q;
        idx0_d  = idx0_q;
        lim1_d  = lim1_q;
        lim0_d  = lim0_q;
        out_d   = out_q;
        err_d   = err_q;
        dwell_d = dwell_q;
        tmo_d   = tmo_q;
        // stop overrides everything, including a coincident start.
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        idx1_d  = '0;
                        idx0_d  = '0;
                        err_d   = 1'b0;
                        lim1_d  = bcd_clamp(lim_bcd1);
                        lim0_d  = bcd_clamp(lim_bcd0);
                        state_d = ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (fib_done) begin
                        out_d   = {fib_d3, fib_d2, fib_d1, fib_d0};
                        dwell_d = '0;
                        state_d = ST_HOLD;
                    end else if (tmo_q == TM_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        tmo_d = tmo_q + TM_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (dwell_q == DW_W'(DWELL - 1)) begin
                        if (at_lim) begin
                            state_d = ST_IDLE;
                        end else begin
                            idx1_d  = inc1;
                            idx0_d  = inc0;
                            state_d = ST_LAUNCH;
                        end
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx1_q  <= '0;
            idx0_q  <= '0;
            lim1_q  <= '0;
            lim0_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            dwell_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx1_q  <= idx1_d;
            idx0_q  <= idx0_d;
            lim1_q  <= lim1_d;
            lim0_q  <= lim0_d;
            out_q   <= out_d;
            err_q   <= err_d;
            dwell_q <= dwell_d;
            tmo_q   <= tmo_d;
        end
    end

    assign fib_start = (state_q == ST_LAUNCH);
    assign busy      = (state_q == ST_LAUNCH) || (state_q == ST_WAIT) || (state_q == ST_HOLD);
    assign err       = err_q;
    assign fib_bcd1  = idx1_q;
    assign fib_bcd0  = idx0_q;
    assign out_d3    = out_q[3*BCD_W +: BCD_W];
    assign out_d2    = out_q[2*BCD_W +: BCD_W];
    assign out_d1    = out_q[1*BCD_W +: BCD_W];
    assign out_d0    = out_q[0*BCD_W +: BCD_W];

endmodule
